// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: data over instruction, grant locked per transaction.
// Define MEM_ARB_FAIRNESS_EN to bound instruction-fetch starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t state;
  logic   dreq;
  logic   done;
  logic   pick_i;

  assign dreq = dREN | dWEN;
  assign done = (ramstate == RAM_ACCESS);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [CNT_W-1:0] cnt;
  logic             cnt_full;

  assign cnt_full = (cnt == CNT_W'(STARVE_LIMIT));
  assign pick_i   = iREN & cnt_full;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (!iREN) cnt <= '0;
        GRANT_D:
          if (done && iREN && !cnt_full)
            cnt <= cnt + 1'b1;
        GRANT_I:
          if (done) cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{STARVE_LIMIT[0], CNT_W[0]};
  assign pick_i     = 1'b0;
`endif

  // A grant ends on completion, error (retry via IDLE) or withdrawal.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_i)    state <= GRANT_I;
          else if (dreq) state <= GRANT_D;
          else if (iREN) state <= GRANT_I;
        end
        GRANT_D:
          if (!dreq || done || ramstate == RAM_ERROR)
            state <= IDLE;
        GRANT_I:
          if (!iREN || done || ramstate == RAM_ERROR)
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      GRANT_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~done;
      end
      GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~done;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Build with MEM_ARB_FAIRNESS_EN to check the fairness guard.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int kinds[$];

  initial begin
    nRST = 1'b0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    tick(); tick();
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    nRST = 1'b1;
    tick();

    // single instruction fetch
    iREN = 1; iaddr = 32'h100; ramload = 32'hDEADBEEF;
    #1 chk("i_idle_ren", 32'(ramREN), 0);
    tick();
    chk("i_ren", 32'(ramREN), 1);
    chk("i_addr", ramaddr, 32'h100);
    chk("i_wait_free", 32'(iwait), 1);
    ramstate = ACCESS;
    #1 chk("i_wait_acc", 32'(iwait), 0);
    chk("i_load", iload, 32'hDEADBEEF);
    chk("i_dwait", 32'(dwait), 1);
    tick();
    iREN = 0; ramstate = FREE;
    #1 chk("i_done_ren", 32'(ramREN), 0);
    chk("i_done_iwait", 32'(iwait), 1);
    tick();

    // simultaneous requests: data first
    iREN = 1; iaddr = 32'h300;
    dWEN = 1; daddr = 32'h200; dstore = 32'h55;
    tick();
    chk("p_wen", 32'(ramWEN), 1);
    chk("p_ren", 32'(ramREN), 0);
    chk("p_addr", ramaddr, 32'h200);
    chk("p_store", ramstore, 32'h55);
    chk("p_iwait", 32'(iwait), 1);
    ramstate = ACCESS;
    #1 chk("p_dwait", 32'(dwait), 0);
    tick();
    dWEN = 0; ramstate = FREE;
    #1 chk("p_gap_addr", ramaddr, 0);
    chk("p_gap_wen", 32'(ramWEN), 0);
    tick();
    chk("p_i_addr", ramaddr, 32'h300);
    chk("p_i_ren", 32'(ramREN), 1);

    // BUSY hold in GRANT_I, data request must wait
    ramstate = BUSY; dREN = 1; daddr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      #1 chk("b_addr", ramaddr, 32'h300);
      chk("b_dwait", 32'(dwait), 1);
      chk("b_iwait", 32'(iwait), 1);
      tick();
    end
    ramstate = ACCESS;
    #1 chk("b_iwait_acc", 32'(iwait), 0);
    tick();
    iREN = 0; ramstate = FREE;
    #1 chk("b_gap_ren", 32'(ramREN), 0);
    chk("b_gap_dwait", 32'(dwait), 1);
    tick();
    chk("b_d_addr", ramaddr, 32'h400);
    chk("b_d_ren", 32'(ramREN), 1);

    // ERROR then retry
    ramstate = ERROR;
    #1 chk("e_dwait", 32'(dwait), 1);
    tick();
    chk("e_idle_ren", 32'(ramREN), 0);
    chk("e_idle_dwait", 32'(dwait), 1);
    ramstate = FREE;
    tick();
    chk("e_retry_addr", ramaddr, 32'h400);
    ramstate = ACCESS; ramload = 32'h12345678;
    #1 chk("e_retry_dwait", 32'(dwait), 0);
    chk("e_retry_dload", dload, 32'h12345678);
    tick();
    dREN = 0; ramstate = FREE;
    tick();

    // withdrawn data request
    dREN = 1; daddr = 32'h500; iaddr = 32'h510;
    tick();
    ramstate = BUSY;
    #1 chk("w_ren", 32'(ramREN), 1);
    dREN = 0;
    #1 chk("w_drop", 32'(ramREN), 0);
    tick();
    iREN = 1;
    tick();
    chk("w_i_addr", ramaddr, 32'h510);
    chk("w_i_ren", 32'(ramREN), 1);
    iREN = 0;
    tick(); tick();

    // reset mid-transaction
    dWEN = 1; daddr = 32'h600; dstore = 32'h77; iREN = 1;
    tick();
    ramstate = BUSY;
    #1 chk("r_wen", 32'(ramWEN), 1);
    nRST = 0;
    #1 chk("r_wen_drop", 32'(ramWEN), 0);
    chk("r_ren_drop", 32'(ramREN), 0);
    chk("r_iwait", 32'(iwait), 1);
    chk("r_dwait", 32'(dwait), 1);
    tick();
    chk("r_hold_addr", ramaddr, 0);
    nRST = 1; ramstate = FREE;
    tick();
    chk("r_after_addr", ramaddr, 32'h600);
    chk("r_after_wen", 32'(ramWEN), 1);
    ramstate = ACCESS;
    tick();
    dWEN = 0; iREN = 0; ramstate = FREE;
    tick(); tick();

    // sustained contention
    iREN = 1; dREN = 1; iaddr = 32'h800; daddr = 32'h700;
    ramstate = ACCESS;
    for (int c = 0; c < 40 && kinds.size() < 10; c++) begin
      tick();
      if (!iwait && !dwait) chk("f_both_low", 1, 0);
      if (!dwait) kinds.push_back(0);
      if (!iwait) kinds.push_back(1);
    end
    chk("f_count", kinds.size(), 10);
    for (int k = 0; k < kinds.size(); k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      chk($sformatf("f_kind%0d", k), kinds[k], (k % 5 == 4) ? 1 : 0);
`else
      chk($sformatf("f_kind%0d", k), kinds[k], 0);
`endif
    end
    iREN = 0; dREN = 0; ramstate = FREE;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
